// File: rtl/helios_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : helios_monitor_pkg
// Description : Shared constants, header/summary field layout and FSM state
//               types for the multi-leaf frame monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package helios_monitor_pkg;

  localparam logic [31:0] TERMINATOR = 32'hFFFF_FFFF;

  // Leaf header layout; SUM1 reuses the same placement for the maxima.
  localparam int HDR_CYCLES_LSB   = 0;
  localparam int HDR_CYCLES_WIDTH = 16;
  localparam int HDR_ITERS_LSB    = 16;
  localparam int HDR_ITERS_WIDTH  = 8;

  // SUM0 flag positions
  localparam int SUM_TIMEOUT_BIT  = 31;
  localparam int SUM_MISMATCH_BIT = 30;
  localparam int SUM_EMPTY_BIT    = 29;
  localparam int ROUND_ID_WIDTH   = 16;

  typedef enum logic [1:0] {CH_IDLE, CH_HEADER, CH_BODY, CH_DONE} ch_state_t;
  typedef enum logic [1:0] {MON_IDLE, MON_COLLECT, MON_SUM0, MON_SUM1} mon_state_t;

  function automatic logic [31:0] pack_sum0(input logic timeout, input logic mismatch,
                                            input logic empty,
                                            input logic [ROUND_ID_WIDTH-1:0] round_id);
    logic [31:0] w;
    w                          = '0;
    w[SUM_TIMEOUT_BIT]         = timeout;
    w[SUM_MISMATCH_BIT]        = mismatch;
    w[SUM_EMPTY_BIT]           = empty;
    w[ROUND_ID_WIDTH-1:0]      = round_id;
    return w;
  endfunction

  function automatic logic [31:0] pack_sum1(input logic [HDR_ITERS_WIDTH-1:0] iters,
                                            input logic [HDR_CYCLES_WIDTH-1:0] cycles);
    logic [31:0] w;
    w                                    = '0;
    w[HDR_ITERS_LSB +: HDR_ITERS_WIDTH]   = iters;
    w[HDR_CYCLES_LSB +: HDR_CYCLES_WIDTH] = cycles;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_parser_channel.sv
`default_nettype none
// ============================================================================
// Module      : frame_parser_channel
// Description : Parses one leaf frame (header, body words, terminator) per
//               round. Exposes the captured header for cross-leaf checking.
// Revision    : 1.0 - initial release
// Ports       : clk, reset     - clock, synchronous active-high reset
//               arm            - start waiting for a header (from IDLE only)
//               flush          - force IDLE, drop any partial frame
//               data/valid     - incoming leaf word
//               ready          - word accept (HEADER or BODY)
//               done           - frame complete, waiting for release
//               hdr_strobe     - header captured this cycle
//               hdr_cycles/its - fields of the header being captured
//               empty_err      - frame consisted of a terminator only
//               wc             - saturating body word count
// ============================================================================
module frame_parser_channel
  import helios_monitor_pkg::*;
#(
  parameter int WC_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arm,
  input  logic                       flush,
  input  logic [31:0]                data,
  input  logic                       valid,
  output logic                       ready,
  output logic                       done,
  output logic                       hdr_strobe,
  output logic [HDR_CYCLES_WIDTH-1:0] hdr_cycles,
  output logic [HDR_ITERS_WIDTH-1:0]  hdr_iters,
  output logic                       empty_err,
  output logic [WC_WIDTH-1:0]        wc
);

  ch_state_t           state_q, state_d;
  logic                empty_q, empty_d;
  logic [WC_WIDTH-1:0] wc_q, wc_d;
  logic                fire;
  logic                is_term;

  // ready is a pure decode of the state register, so it never depends on
  // the same-cycle valid or data.
  assign ready      = (state_q == CH_HEADER) || (state_q == CH_BODY);
  assign done       = (state_q == CH_DONE);
  assign fire       = valid & ready;
  assign is_term    = (data == TERMINATOR);
  assign hdr_cycles = data[HDR_CYCLES_LSB +: HDR_CYCLES_WIDTH];
  assign hdr_iters  = data[HDR_ITERS_LSB +: HDR_ITERS_WIDTH];
  assign empty_err  = empty_q;
  assign wc         = wc_q;

  always_comb begin
    state_d    = state_q;
    empty_d    = empty_q;
    wc_d       = wc_q;
    hdr_strobe = 1'b0;
    if (flush) begin
      state_d = CH_IDLE;
    end else begin
      case (state_q)
        CH_IDLE: begin
          if (arm) begin
            state_d = CH_HEADER;
            empty_d = 1'b0;
            wc_d    = '0;
          end
        end
        CH_HEADER: begin
          if (fire) begin
            if (is_term) begin
              empty_d = 1'b1;
              state_d = CH_DONE;
            end else begin
              hdr_strobe = 1'b1;
              state_d    = CH_BODY;
            end
          end
        end
        CH_BODY: begin
          if (fire) begin
            if (is_term) begin
              state_d = CH_DONE;
            end else if (wc_q != {WC_WIDTH{1'b1}}) begin
              wc_d = wc_q + {{(WC_WIDTH-1){1'b0}}, 1'b1};
            end
          end
        end
        default: ;  // CH_DONE: held until the round releases it via flush
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CH_IDLE;
      empty_q <= 1'b0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      empty_q <= empty_d;
      wc_q    <= wc_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_leaf_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module      : multi_leaf_frame_monitor
// Description : Collects one frame per leaf channel per round, checks header
//               consistency, runs a round watchdog and emits a two-word
//               summary (flags + round id, then header maxima).
// Revision    : 1.0 - initial release
// Ports       : clk, reset          - clock, synchronous active-high reset
//               round_start         - arm all channels (honoured in IDLE only)
//               ch_data/valid/ready - per-leaf word streams, ch c at [32c +: 32]
//               summary_data/valid/ready - summary word stream
//               busy                - round in progress
//               timeout_mask        - channels unfinished at the last timeout
//               frames_total        - completed frames since reset
// ============================================================================
module multi_leaf_frame_monitor
  import helios_monitor_pkg::*;
#(
  parameter int NUM_CHANNELS    = 2,
  parameter int TIMEOUT_CYCLES  = 100000,
  parameter int TO_WIDTH        = 32,
  parameter int WC_WIDTH        = 16,
  parameter int FRAME_CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       round_start,
  input  logic [32*NUM_CHANNELS-1:0] ch_data,
  input  logic [NUM_CHANNELS-1:0]    ch_valid,
  output logic [NUM_CHANNELS-1:0]    ch_ready,
  output logic [31:0]                summary_data,
  output logic                       summary_valid,
  input  logic                       summary_ready,
  output logic                       busy,
  output logic [NUM_CHANNELS-1:0]    timeout_mask,
  output logic [FRAME_CNT_WIDTH-1:0] frames_total
);

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  mon_state_t                  state_q, state_d;
  logic [TO_WIDTH-1:0]         wd_q, wd_d;
  logic [ROUND_ID_WIDTH-1:0]   round_id_q, round_id_d;
  logic                        ref_valid_q, ref_valid_d;
  logic [HDR_CYCLES_WIDTH-1:0] ref_cycles_q, ref_cycles_d;
  logic [HDR_CYCLES_WIDTH-1:0] max_cycles_q, max_cycles_d;
  logic [HDR_ITERS_WIDTH-1:0]  max_iters_q, max_iters_d;
  logic                        mismatch_q, mismatch_d;
  logic [NUM_CHANNELS-1:0]     timeout_mask_q, timeout_mask_d;
  logic [FRAME_CNT_WIDTH-1:0]  frames_q, frames_d;
  logic [31:0]                 sum_data_q, sum_data_d;
  logic                        sum_valid_q, sum_valid_d;

  logic                        arm;
  logic [NUM_CHANNELS-1:0]     flush;
  logic [NUM_CHANNELS-1:0]     done_vec, empty_vec, hdr_strobe, enter_done;
  logic [HDR_CYCLES_WIDTH-1:0] hdr_cycles [NUM_CHANNELS];
  logic [HDR_ITERS_WIDTH-1:0]  hdr_iters  [NUM_CHANNELS];
  // Per-channel body word counts; kept for debug visibility only.
  logic [WC_WIDTH-1:0]         wc_unused  [NUM_CHANNELS];
  logic                        all_done;
  logic                        timeout_hit;

  genvar c;
  generate
    for (c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      frame_parser_channel #(.WC_WIDTH(WC_WIDTH)) u_parser (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .flush      (flush[c]),
        .data       (ch_data[32*c +: 32]),
        .valid      (ch_valid[c]),
        .ready      (ch_ready[c]),
        .done       (done_vec[c]),
        .hdr_strobe (hdr_strobe[c]),
        .hdr_cycles (hdr_cycles[c]),
        .hdr_iters  (hdr_iters[c]),
        .empty_err  (empty_vec[c]),
        .wc         (wc_unused[c])
      );
      // A terminator accepted in HEADER or BODY moves the channel to DONE,
      // unless the same cycle's timeout flush discards it.
      assign enter_done[c] = ch_valid[c] & ch_ready[c] & ~flush[c] &
                             (ch_data[32*c +: 32] == TERMINATOR);
    end
  endgenerate

  assign all_done    = &done_vec;
  // all-DONE has priority: no timeout once every channel is finished.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wd_q == TO_LAST) && !all_done;

  always_comb begin
    state_d        = state_q;
    wd_d           = wd_q;
    round_id_d     = round_id_q;
    ref_valid_d    = ref_valid_q;
    ref_cycles_d   = ref_cycles_q;
    max_cycles_d   = max_cycles_q;
    max_iters_d    = max_iters_q;
    mismatch_d     = mismatch_q;
    timeout_mask_d = timeout_mask_q;
    frames_d       = frames_q;
    sum_data_d     = sum_data_q;
    sum_valid_d    = sum_valid_q;
    arm            = 1'b0;
    flush          = '0;

    // Walk channels in index order so the lowest simultaneous header becomes
    // the reference and later ones in the same cycle compare against it.
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (hdr_strobe[i]) begin
        if (!ref_valid_d) begin
          ref_valid_d  = 1'b1;
          ref_cycles_d = hdr_cycles[i];
        end else if (hdr_cycles[i] != ref_cycles_d) begin
          mismatch_d = 1'b1;
        end
        if (hdr_cycles[i] > max_cycles_d) max_cycles_d = hdr_cycles[i];
        if (hdr_iters[i]  > max_iters_d)  max_iters_d  = hdr_iters[i];
      end
      frames_d = frames_d + FRAME_CNT_WIDTH'(enter_done[i]);
    end

    case (state_q)
      MON_IDLE: begin
        if (round_start) begin
          state_d        = MON_COLLECT;
          arm            = 1'b1;
          wd_d           = '0;
          ref_valid_d    = 1'b0;
          mismatch_d     = 1'b0;
          max_cycles_d   = '0;
          max_iters_d    = '0;
          timeout_mask_d = '0;
        end
      end
      MON_COLLECT: begin
        wd_d = wd_q + TO_WIDTH'(1);
        if (all_done) begin
          state_d     = MON_SUM0;
          sum_valid_d = 1'b1;
          sum_data_d  = pack_sum0(1'b0, mismatch_d, |empty_vec, round_id_q);
        end else if (timeout_hit) begin
          state_d        = MON_SUM0;
          timeout_mask_d = ~done_vec;
          flush          = ~done_vec;
          sum_valid_d    = 1'b1;
          sum_data_d     = pack_sum0(1'b1, mismatch_d, |empty_vec, round_id_q);
        end
      end
      MON_SUM0: begin
        if (summary_ready) begin
          state_d    = MON_SUM1;
          sum_data_d = pack_sum1(max_iters_q, max_cycles_q);
        end
      end
      default: begin  // MON_SUM1
        if (summary_ready) begin
          state_d     = MON_IDLE;
          sum_valid_d = 1'b0;
          sum_data_d  = '0;
          round_id_d  = round_id_q + ROUND_ID_WIDTH'(1);
          flush       = '1;  // release DONE channels for the next round
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= MON_IDLE;
      wd_q           <= '0;
      round_id_q     <= '0;
      ref_valid_q    <= 1'b0;
      ref_cycles_q   <= '0;
      max_cycles_q   <= '0;
      max_iters_q    <= '0;
      mismatch_q     <= 1'b0;
      timeout_mask_q <= '0;
      frames_q       <= '0;
      sum_data_q     <= '0;
      sum_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      wd_q           <= wd_d;
      round_id_q     <= round_id_d;
      ref_valid_q    <= ref_valid_d;
      ref_cycles_q   <= ref_cycles_d;
      max_cycles_q   <= max_cycles_d;
      max_iters_q    <= max_iters_d;
      mismatch_q     <= mismatch_d;
      timeout_mask_q <= timeout_mask_d;
      frames_q       <= frames_d;
      sum_data_q     <= sum_data_d;
      sum_valid_q    <= sum_valid_d;
    end
  end

  assign summary_data  = sum_data_q;
  assign summary_valid = sum_valid_q;
  assign busy          = (state_q != MON_IDLE);
  assign timeout_mask  = timeout_mask_q;
  assign frames_total  = frames_q;

endmodule
`default_nettype wire
